// File: rtl/gates_sweep_unit.sv
// Registered WIDTH-bit bitwise logic unit with a valid/ready output stage and
// a built-in exhaustive (A,B) sweep that folds every result into a signature.
module gates_sweep_unit #(
  parameter int WIDTH = 4,
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [WIDTH-1:0]   sweep_r;
  logic               xfer;
  logic               start_accept;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = ~x;
      3'd3:    r = x ^ z;
      3'd4:    r = ~(x & z);
      3'd5:    r = ~(x | z);
      3'd6:    r = ~(x ^ z);
      default: r = ~z;
    endcase
    return r;
  endfunction

  // The OR form keeps the rotate legal for a 1-bit signature as well.
  function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
    return (v << 1) | (v >> (SIG_W - 1));
  endfunction

  assign xfer         = in_valid && in_ready;
  assign start_accept = (state_q == ST_IDLE) && start && !out_valid_q && !in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sig_q       <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_accept) state_d = ST_SWEEP;
      ST_SWEEP: if (cnt_q == CNT_MAX) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sweep operands come straight from the counter: upper half is A, lower half is B.
  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sig_d       = sig_q;
    sweep_r     = logic_op(op_q, cnt_q[CNT_W-1:WIDTH], cnt_q[WIDTH-1:0]);
    if (state_q == ST_IDLE) begin
      if (xfer) begin
        y_d         = logic_op(op, a, b);
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (start_accept) begin
        op_d  = op;
        cnt_d = '0;
        sig_d = '0;
      end
    end else if (state_q == ST_SWEEP) begin
      sig_d = rotl1(sig_q) ^ SIG_W'(sweep_r);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    busy     = (state_q == ST_SWEEP);
    done     = (state_q == ST_DONE);
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_gates_sweep_unit.sv
// Self-checking bench: one WIDTH=4 and one WIDTH=1 instance against an
// arithmetic reference model of the op table, handshake and sweep signature.
module tb_gates_sweep_unit;

  logic        clk;
  int          n_checks;
  int          n_fail;

  logic        rst4_n, iv4, ir4, ov4, or4, st4, busy4, done4;
  logic [3:0]  a4, b4, y4;
  logic [2:0]  op4;
  logic [15:0] sig4;

  logic        rst1_n, iv1, ir1, ov1, or1, st1, busy1, done1;
  logic [0:0]  a1, b1, y1;
  logic [2:0]  op1;
  logic [15:0] sig1;

  gates_sweep_unit #(.WIDTH(4), .SIG_W(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .op(op4), .in_valid(iv4),
    .in_ready(ir4), .y(y4), .out_valid(ov4), .out_ready(or4), .start(st4),
    .busy(busy4), .done(done4), .signature(sig4)
  );

  gates_sweep_unit #(.WIDTH(1), .SIG_W(16)) dut1 (
    .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .op(op1), .in_valid(iv1),
    .in_ready(ir1), .y(y1), .out_valid(ov1), .out_ready(or1), .start(st1),
    .busy(busy1), .done(done1), .signature(sig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_op(input int sel, input int x, input int z, input int w);
    int mask;
    mask = (1 << w) - 1;
    case (sel)
      0: return x & z;
      1: return x | z;
      2: return mask - x;
      3: return x ^ z;
      4: return mask - (x & z);
      5: return mask - (x | z);
      6: return mask - (x ^ z);
      default: return mask - z;
    endcase
  endfunction

  function automatic int model_sig(input int sel, input int w);
    int s;
    s = 0;
    for (int ai = 0; ai < (1 << w); ai++)
      for (int bi = 0; bi < (1 << w); bi++)
        s = (((s * 2) % 65536) + (s / 32768)) ^ model_op(sel, ai, bi, w);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4_n = 0; rst1_n = 0;
    {iv4, or4, st4, iv1, or1, st1} = '0;
    a4 = 0; b4 = 0; op4 = 0; a1 = 0; b1 = 0; op1 = 0;
    #2;
    if ({y4, ov4, busy4, done4, sig4} !== 23'd0) begin
      $display("[TB] FAIL reset4: got y=%h ov=%b busy=%b done=%b sig=%h expected all zero",
               y4, ov4, busy4, done4, sig4);
      n_fail++;
    end
    n_checks++;
    if ({y1, ov1, busy1, done1, sig1} !== 20'd0) begin
      $display("[TB] FAIL reset1: got y=%h ov=%b busy=%b done=%b sig=%h expected all zero",
               y1, ov1, busy1, done1, sig1);
      n_fail++;
    end
    n_checks++;
    step();
    rst4_n = 1; rst1_n = 1;
  endtask

  task automatic test_single();
    a4 = 4'hC; b4 = 4'hA; op4 = 3; iv4 = 1; or4 = 1;
    #1;
    if (ir4 !== 1'b1) begin
      $display("[TB] FAIL single_in_ready: got %b expected 1", ir4); n_fail++;
    end
    n_checks++;
    step();
    iv4 = 0;
    if (y4 !== 4'h6 || ov4 !== 1'b1) begin
      $display("[TB] FAIL single_xor: got y=%h ov=%b expected y=6 ov=1", y4, ov4); n_fail++;
    end
    n_checks++;
    step();
    if (ov4 !== 1'b0) begin
      $display("[TB] FAIL single_consume: got ov=%b expected 0", ov4); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int exp_y;
    a4 = 4'hC; b4 = 4'hA; or4 = 1; iv4 = 1;
    for (int k = 0; k < 3; k++) begin
      op4 = 3'(k);
      exp_y = model_op(k, 12, 10, 4);
      step();
      if (y4 !== 4'(exp_y) || ov4 !== 1'b1 || ir4 !== 1'b1) begin
        $display("[TB] FAIL b2b_op%0d: got y=%h ov=%b ir=%b expected y=%h ov=1 ir=1",
                 k, y4, ov4, ir4, exp_y);
        n_fail++;
      end
      n_checks++;
    end
    iv4 = 0;
    step();
  endtask

  task automatic test_stall();
    a4 = 4'hC; b4 = 4'hA; op4 = 4; iv4 = 1; or4 = 0;
    step();
    op4 = 0;
    if (y4 !== 4'h7 || ov4 !== 1'b1 || ir4 !== 1'b0) begin
      $display("[TB] FAIL stall_first: got y=%h ov=%b ir=%b expected y=7 ov=1 ir=0", y4, ov4, ir4);
      n_fail++;
    end
    n_checks++;
    step();
    if (y4 !== 4'h7 || ov4 !== 1'b1) begin
      $display("[TB] FAIL stall_hold: got y=%h ov=%b expected y=7 ov=1", y4, ov4); n_fail++;
    end
    n_checks++;
    or4 = 1;
    step();
    iv4 = 0;
    if (y4 !== 4'h8 || ov4 !== 1'b1) begin
      $display("[TB] FAIL stall_release: got y=%h ov=%b expected y=8 ov=1", y4, ov4); n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_random_stream();
    int my, ma, mb, mop;
    bit mv, exp_ir, errs;
    errs = 0;
    rst4_n = 0; #1; rst4_n = 1;
    my = 0; mv = 0;
    for (int k = 0; k < 200; k++) begin
      ma = $urandom_range(15); mb = $urandom_range(15); mop = $urandom_range(7);
      a4 = 4'(ma); b4 = 4'(mb); op4 = 3'(mop);
      iv4 = 1'($urandom_range(1)); or4 = 1'($urandom_range(1));
      #1;
      exp_ir = !mv || or4;
      if (ir4 !== exp_ir && !errs) begin
        $display("[TB] FAIL rand_in_ready@%0d: got %b expected %b", k, ir4, exp_ir);
        errs = 1;
      end
      if (iv4 && exp_ir) begin
        my = model_op(mop, ma, mb, 4); mv = 1;
      end else if (mv && or4) begin
        mv = 0;
      end
      step();
      if ((y4 !== 4'(my) || ov4 !== mv) && !errs) begin
        $display("[TB] FAIL rand_result@%0d: got y=%h ov=%b expected y=%h ov=%b", k, y4, ov4, my, mv);
        errs = 1;
      end
    end
    if (errs) n_fail++;
    n_checks++;
    iv4 = 0; or4 = 1;
    step(); step();
  endtask

  task automatic sweep1(input int sel);
    int n, ndone, exp_sig;
    exp_sig = model_sig(sel, 1);
    op1 = 3'(sel); st1 = 1; iv1 = 0;
    step();
    st1 = 0;
    n = 0;
    while (busy1 === 1'b1 && n < 50) begin
      n++;
      step();
    end
    ndone = 0;
    if (done1 === 1'b1) ndone++;
    if (sig1 !== 16'(exp_sig)) begin
      $display("[TB] FAIL sweep1_op%0d_sig: got %h expected %h", sel, sig1, exp_sig); n_fail++;
    end
    n_checks++;
    step();
    if (done1 === 1'b1) ndone++;
    if (n !== 4 || ndone !== 1) begin
      $display("[TB] FAIL sweep1_op%0d_timing: got busy=%0d done=%0d expected busy=4 done=1",
               sel, n, ndone);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_sweep_w1();
    sweep1(0);
    sweep1(1);
    sweep1(3);
    sweep1($urandom_range(7));
  endtask

  task automatic test_sweep_w4();
    int n, exp_sig;
    logic [3:0] y_before;
    bit leak;
    exp_sig = model_sig(5, 4);
    y_before = y4;
    leak = 0;
    or4 = 0; op4 = 5; st4 = 1; iv4 = 0;
    step();
    st4 = 0;
    n = 0;
    while (busy4 === 1'b1 && n < 400) begin
      if (n == 100) begin
        st4 = 1; iv4 = 1; op4 = 0; a4 = 4'hF; b4 = 4'hF;
        #1;
        if (ir4 !== 1'b0) leak = 1;
      end else begin
        st4 = 0; iv4 = 0;
      end
      if (ov4 !== 1'b0 || y4 !== y_before) leak = 1;
      n++;
      step();
    end
    st4 = 0; iv4 = 0;
    if (n !== 256 || done4 !== 1'b1) begin
      $display("[TB] FAIL sweep4_busy: got busy=%0d done=%b expected busy=256 done=1", n, done4);
      n_fail++;
    end
    n_checks++;
    if (leak) begin
      $display("[TB] FAIL sweep4_ignore: got in_ready/out_valid activity expected none");
      n_fail++;
    end
    n_checks++;
    if (sig4 !== 16'(exp_sig)) begin
      $display("[TB] FAIL sweep4_sig: got %h expected %h", sig4, exp_sig); n_fail++;
    end
    n_checks++;
    step();
    if (done4 !== 1'b0 || busy4 !== 1'b0 || sig4 !== 16'(exp_sig)) begin
      $display("[TB] FAIL sweep4_after: got done=%b busy=%b sig=%h expected 0 0 %h",
               done4, busy4, sig4, exp_sig);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_sweep();
    bit saw_done;
    op1 = 1; st1 = 1; or1 = 1;
    step();
    st1 = 0;
    step(); step();
    rst1_n = 0;
    #1;
    if (busy1 !== 1'b0 || sig1 !== 16'h0 || done1 !== 1'b0) begin
      $display("[TB] FAIL abort_async: got busy=%b sig=%h done=%b expected 0 0 0", busy1, sig1, done1);
      n_fail++;
    end
    n_checks++;
    step();
    rst1_n = 1;
    #1;
    if (ir1 !== 1'b1) begin
      $display("[TB] FAIL abort_in_ready: got %b expected 1", ir1); n_fail++;
    end
    n_checks++;
    saw_done = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1;
    end
    if (saw_done) begin
      $display("[TB] FAIL abort_no_done: got done/busy activity expected none"); n_fail++;
    end
    n_checks++;
    sweep1(3);
  endtask

  task automatic test_async_reset_result();
    a4 = 4'hF; b4 = 4'h0; op4 = 1; iv4 = 1; or4 = 0;
    step();
    iv4 = 0;
    #2;
    rst4_n = 0;
    #1;
    if (y4 !== 4'h0 || ov4 !== 1'b0) begin
      $display("[TB] FAIL async_reset: got y=%h ov=%b expected y=0 ov=0", y4, ov4); n_fail++;
    end
    n_checks++;
    rst4_n = 1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random_stream();
    test_sweep_w1();
    test_sweep_w4();
    test_reset_mid_sweep();
    test_async_reset_result();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
